// File: rtl/tia_playfield_hsync.sv
// Horizontal line counter, sync/blank timing, WSYNC/RSYNC handshake and playfield serializer.
// Decoded outputs are combinational from registered state; register writes show on pf one clock later.
module tia_playfield_hsync #(
  parameter logic [7:0] LINE_LEN    = 8'd228,
  parameter logic [7:0] HBLANK_END  = 8'd68,
  parameter logic [7:0] HSYNC_START = 8'd20,
  parameter logic [7:0] HSYNC_END   = 8'd36
) (
  input  logic       clkp,
  input  logic       reset,
  input  logic [7:0] d,
  input  logic       pf0ci,
  input  logic       pf1ci,
  input  logic       pf2ci,
  input  logic       ctrlpfci,
  input  logic       wsync,
  input  logic       rsync,
  output logic [7:0] hcount,
  output logic       pf,
  output logic       blank,
  output logic       cntd,
  output logic       hsync,
  output logic       score_bar,
  output logic       pfp_bar,
  output logic       rdy
);

  logic [3:0]  pf0_q;
  logic [7:0]  pf1_q;
  logic [7:0]  pf2_q;
  logic        ref_q;
  logic        score_q;
  logic        pfp_q;
  logic        line_wrap;
  logic [7:0]  x;
  logic [7:0]  x_half;
  logic        right;
  logic [4:0]  bit_i;
  logic [4:0]  bit_sel;
  logic [31:0] pf_bits;

  assign line_wrap = (hcount == LINE_LEN - 8'd1);

  always_ff @(posedge clkp or posedge reset) begin
    if (reset) begin
      hcount <= 8'd0;
    end else if (rsync || line_wrap) begin
      hcount <= 8'd0;
    end else begin
      hcount <= hcount + 8'd1;
    end
  end

  // WSYNC only arms from the running state, so a strobe on the wrap edge holds the CPU a full line.
  always_ff @(posedge clkp or posedge reset) begin
    if (reset) begin
      rdy <= 1'b1;
    end else if (wsync && rdy) begin
      rdy <= 1'b0;
    end else if (line_wrap || rsync) begin
      rdy <= 1'b1;
    end
  end

  always_ff @(posedge clkp or posedge reset) begin
    if (reset) begin
      pf0_q   <= 4'd0;
      pf1_q   <= 8'd0;
      pf2_q   <= 8'd0;
      ref_q   <= 1'b0;
      score_q <= 1'b0;
      pfp_q   <= 1'b0;
    end else begin
      if (pf0ci) pf0_q <= d[7:4];
      if (pf1ci) pf1_q <= d;
      if (pf2ci) pf2_q <= d;
      if (ctrlpfci) begin
        ref_q   <= d[0];
        score_q <= d[1];
        pfp_q   <= d[2];
      end
    end
  end

  // Playfield order across one half-line: PF0 d4..d7, PF1 d7..d0, PF2 d0..d7.
  always_comb begin
    pf_bits = '0;
    for (int k = 0; k < 4; k++) pf_bits[k] = pf0_q[k];
    for (int k = 0; k < 8; k++) begin
      pf_bits[4 + k]  = pf1_q[7 - k];
      pf_bits[12 + k] = pf2_q[k];
    end
  end

  assign blank   = (hcount < HBLANK_END);
  assign x       = hcount - HBLANK_END;
  assign right   = (x >= 8'd80);
  assign x_half  = right ? (x - 8'd80) : x;
  assign bit_i   = 5'(x_half >> 2);
  assign bit_sel = (right && ref_q) ? (5'd19 - bit_i) : bit_i;

  assign pf        = ~blank & pf_bits[bit_sel];
  assign cntd      = ~blank & right;
  assign hsync     = (hcount >= HSYNC_START) && (hcount < HSYNC_END);
  assign score_bar = ~score_q;
  assign pfp_bar   = ~pfp_q;

endmodule

// File: tb/tb_tia_playfield_hsync.sv
// Directed timing scenarios plus randomized register/sync traffic against a behavioural line model.
module tb_tia_playfield_hsync;

  logic       clkp = 1'b0;
  logic       reset;
  logic [7:0] d;
  logic       pf0ci, pf1ci, pf2ci, ctrlpfci, wsync, rsync;
  logic [7:0] hcount;
  logic       pf, blank, cntd, hsync, score_bar, pfp_bar, rdy;

  int checks = 0;
  int errors = 0;

  // reference model state
  int       m_hc;
  logic [7:0] m_pf0, m_pf1, m_pf2;
  logic     m_ref, m_score, m_pfp, m_rdy;

  tia_playfield_hsync dut (
    .clkp(clkp), .reset(reset), .d(d),
    .pf0ci(pf0ci), .pf1ci(pf1ci), .pf2ci(pf2ci), .ctrlpfci(ctrlpfci),
    .wsync(wsync), .rsync(rsync),
    .hcount(hcount), .pf(pf), .blank(blank), .cntd(cntd), .hsync(hsync),
    .score_bar(score_bar), .pfp_bar(pfp_bar), .rdy(rdy)
  );

  always #5 clkp = ~clkp;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (model hcount %0d)", tag, got, exp, m_hc);
    end
  endtask

  function automatic int exp_pf();
    int x, i;
    if (m_hc < 68) return 0;
    x = m_hc - 68;
    i = (x % 80) / 4;
    if (x >= 80 && m_ref) i = 19 - i;
    if (i < 4)       return int'(m_pf0[4 + i]);
    else if (i < 12) return int'(m_pf1[11 - i]);
    else             return int'(m_pf2[i - 12]);
  endfunction

  task automatic model_reset();
    m_hc = 0; m_pf0 = 0; m_pf1 = 0; m_pf2 = 0;
    m_ref = 0; m_score = 0; m_pfp = 0; m_rdy = 1;
  endtask

  task automatic model_edge();
    logic new_rdy;
    new_rdy = m_rdy;
    if (m_hc == 227 || rsync) new_rdy = 1'b1;
    if (wsync && m_rdy) new_rdy = 1'b0;
    m_rdy = new_rdy;
    if (pf0ci) m_pf0 = d;
    if (pf1ci) m_pf1 = d;
    if (pf2ci) m_pf2 = d;
    if (ctrlpfci) begin m_ref = d[0]; m_score = d[1]; m_pfp = d[2]; end
    m_hc = rsync ? 0 : (m_hc + 1) % 228;
  endtask

  task automatic compare_all();
    chk("hcount", hcount, m_hc);
    chk("pf", pf, exp_pf());
    chk("blank", blank, int'(m_hc < 68));
    chk("cntd", cntd, int'(m_hc >= 148));
    chk("hsync", hsync, int'(m_hc >= 20 && m_hc < 36));
    chk("score_bar", score_bar, int'(!m_score));
    chk("pfp_bar", pfp_bar, int'(!m_pfp));
    chk("rdy", rdy, int'(m_rdy));
  endtask

  task automatic clear_inputs();
    d = 8'h00; pf0ci = 0; pf1ci = 0; pf2ci = 0; ctrlpfci = 0; wsync = 0; rsync = 0;
  endtask

  // one clock: inputs set at negedge are taken at posedge, outputs checked at the next negedge
  task automatic cyc();
    @(posedge clkp);
    model_edge();
    @(negedge clkp);
    compare_all();
    clear_inputs();
  endtask

  task automatic run_to(input int target);
    for (int n = 0; n < 300 && m_hc != target; n++) cyc();
    chk("run_to", hcount, target);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(negedge clkp);
    reset = 1'b0;

    // asynchronous reset mid-line
    run_to(150);
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_hcount", hcount, 0);
    chk("rst_rdy", rdy, 1);
    chk("rst_pf", pf, 0);
    chk("rst_blank", blank, 1);
    chk("rst_score_bar", score_bar, 1);
    chk("rst_pfp_bar", pfp_bar, 1);
    #2;
    reset = 1'b0;
    cyc();
    chk("first_inc", hcount, 1);

    // PF0=F0, REF=0
    run_to(227);
    d = 8'hF0; pf0ci = 1;
    cyc();
    for (int n = 0; n < 228; n++) begin
      chk("t2_pf", pf, int'((m_hc >= 68 && m_hc <= 83) || (m_hc >= 148 && m_hc <= 163)));
      chk("t2_cntd", cntd, int'(m_hc >= 148));
      chk("t2_hsync", hsync, int'(m_hc >= 20 && m_hc <= 35));
      cyc();
    end

    // PF2=80 with REF=1, then REF=0
    run_to(227);
    d = 8'h80; pf2ci = 1; pf0ci = 1; pf1ci = 1; ctrlpfci = 1;
    cyc();
    // the shared bus loaded 0x80 into PF0/PF1 too; clear them (REF stays 0 after this)
    d = 8'h00; pf0ci = 1; pf1ci = 1;
    cyc();
    chk("t3_setup", hcount, 1);
    d = 8'h01; ctrlpfci = 1;
    run_to(227);
    d = 8'h01; ctrlpfci = 1;
    cyc();
    for (int n = 0; n < 228; n++) begin
      chk("t3_ref1_pf", pf, int'(m_hc >= 144 && m_hc <= 151));
      cyc();
    end
    run_to(227);
    d = 8'h00; ctrlpfci = 1;
    cyc();
    for (int n = 0; n < 228; n++) begin
      chk("t3_ref0_pf", pf, int'((m_hc >= 144 && m_hc <= 147) || (m_hc >= 224)));
      cyc();
    end

    // mid-line PF1 write
    d = 8'h00; pf2ci = 1;
    cyc();
    run_to(100);
    chk("t4_pf_100", pf, 0);
    d = 8'hFF; pf1ci = 1;
    cyc();
    for (int n = 0; n < 16; n++) begin
      chk("t4_pf", pf, int'(m_hc <= 115));
      cyc();
    end

    // WSYNC mid-line and on the wrap edge
    run_to(10);
    wsync = 1;
    cyc();
    for (int n = 0; n < 300 && m_hc != 0; n++) begin
      chk("t5_rdy_low", rdy, 0);
      cyc();
    end
    chk("t5_rdy_release", rdy, 1);
    run_to(227);
    wsync = 1;
    cyc();
    for (int n = 0; n < 228; n++) begin
      chk("t5_wrap_rdy_low", rdy, 0);
      cyc();
    end
    chk("t5_wrap_release", rdy, 1);

    // RSYNC while halted, then CTRLPF=06
    run_to(40);
    wsync = 1;
    cyc();
    run_to(90);
    chk("t6_rdy_halted", rdy, 0);
    rsync = 1;
    cyc();
    chk("t6_hcount", hcount, 0);
    chk("t6_rdy", rdy, 1);
    d = 8'h06; ctrlpfci = 1;
    cyc();
    chk("t6_score_bar", score_bar, 0);
    chk("t6_pfp_bar", pfp_bar, 0);

    // randomized traffic
    for (int n = 0; n < 5000; n++) begin
      d        = 8'($urandom);
      pf0ci    = ($urandom_range(0, 15) == 0);
      pf1ci    = ($urandom_range(0, 15) == 0);
      pf2ci    = ($urandom_range(0, 15) == 0);
      ctrlpfci = ($urandom_range(0, 31) == 0);
      wsync    = ($urandom_range(0, 39) == 0);
      rsync    = ($urandom_range(0, 399) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
